// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pkg
//  Purpose  : Shared types and default sizing for the FIR delay-line
//             controller, sample RAM and MAC stage.
//  Contents : fir_state_t      - controller state encoding (2 bits)
//             c_default_*      - default address/sample/tap sizing
//  Revision : 1.0  initial release
// ============================================================================
package fir_pkg;

    // Default sizing shared by the controller, the RAM and the MAC
    localparam int c_default_a_width = 16;
    localparam int c_default_d_width = 24;
    localparam int c_default_taps    = 32;

    // Controller state encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } fir_state_t;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_tap_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fir_tap_pipe
//  Purpose  : One-cycle alignment stage for the tap sideband. The RAM read
//             data arrives one cycle after the address, so the read-phase
//             flag and tap index are delayed by one register to line up with
//             it.
//  Ports    : clk, rst          clock / synchronous active-high reset
//             i_rd_en           controller is issuing a tap read this cycle
//             i_rd_idx          tap index of the read being issued
//             o_tap_valid       read data on the RAM port is a valid tap
//             o_tap_idx         tap index aligned with the read data
//             o_tap_last        aligned tap is the oldest (idx == TAPS-1)
//  Revision : 1.0  initial release
// ============================================================================
module fir_tap_pipe #(
    parameter int TAPS    = 32,
    parameter int T_WIDTH = $clog2(TAPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_rd_en,
    input  logic [T_WIDTH-1:0] i_rd_idx,
    output logic               o_tap_valid,
    output logic [T_WIDTH-1:0] o_tap_idx,
    output logic               o_tap_last
);

    logic               r_valid;
    logic [T_WIDTH-1:0] r_idx;
    logic               r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= i_rd_en;
            r_idx   <= i_rd_idx;
            // Registering the qualified compare keeps tap_last free of
            // output-side combinational logic.
            r_last  <= i_rd_en && (i_rd_idx == T_WIDTH'(TAPS - 1));
        end
    end

    assign o_tap_valid = r_valid;
    assign o_tap_idx   = r_idx;
    assign o_tap_last  = r_last;

endmodule : fir_tap_pipe
`default_nettype wire

// File: rtl/fir_delay_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fir_delay_line_ctrl
//  Purpose  : Runs a single-port sample RAM as a circular FIR delay line.
//             Each accepted sample is written at the write pointer, then the
//             newest TAPS samples are read back newest-first and streamed to
//             the MAC with their tap index.
//  Ports    : clk, rst                 clock / synchronous active-high reset
//             in_valid/in_ready/in_data  sample input handshake
//             ram_cs/we/addr/wdata     RAM command (sole master)
//             ram_rdata                RAM read data, 1-cycle latency
//             tap_valid/data/idx/last  tap stream to the MAC
//             busy                     controller not idle
//  Revision : 1.0  initial release
// ============================================================================
module fir_delay_line_ctrl
    import fir_pkg::*;
#(
    parameter int A_WIDTH = c_default_a_width,
    parameter int D_WIDTH = c_default_d_width,
    parameter int TAPS    = c_default_taps,
    parameter int T_WIDTH = $clog2(TAPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_data,
    output logic               ram_cs,
    output logic               ram_we,
    output logic [A_WIDTH-1:0] ram_addr,
    output logic [D_WIDTH-1:0] ram_wdata,
    input  logic [D_WIDTH-1:0] ram_rdata,
    output logic               tap_valid,
    output logic [D_WIDTH-1:0] tap_data,
    output logic [T_WIDTH-1:0] tap_idx,
    output logic               tap_last,
    output logic               busy
);

    fir_state_t         r_state;
    fir_state_t         w_state_nxt;
    logic [A_WIDTH-1:0] r_wr_ptr;
    logic [T_WIDTH-1:0] r_k;
    logic [D_WIDTH-1:0] r_sample;

    logic w_accept;
    logic w_k_last;
    logic w_rd_en;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_k_last = (r_k == T_WIDTH'(TAPS - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_READ;
            S_READ:  if (w_k_last) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointer, tap counter and sample latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_k      <= '0;
            r_sample <= '0;
        end else begin
            // Only the IDLE-cycle sample is captured; data presented while
            // busy is ignored.
            if (w_accept) begin
                r_sample <= in_data;
            end
            case (r_state)
                S_WRITE: r_k <= '0;
                S_READ:  if (!w_k_last) r_k <= r_k + T_WIDTH'(1);
                // Pointer advances only after the whole read burst so every
                // read address is relative to the slot just written.
                S_DRAIN: r_wr_ptr <= r_wr_ptr + A_WIDTH'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode: registered state only, no input-to-output paths
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = r_wr_ptr;
        ram_wdata = r_sample;
        w_rd_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_WRITE: begin
                ram_cs = 1'b1;
                ram_we = 1'b1;
            end
            S_READ: begin
                ram_cs   = 1'b1;
                // Unsigned subtraction wraps modulo the RAM depth.
                ram_addr = r_wr_ptr - A_WIDTH'(r_k);
                w_rd_en  = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Tap sideband alignment with the 1-cycle RAM read latency
    // ------------------------------------------------------------------
    fir_tap_pipe #(
        .TAPS    (TAPS),
        .T_WIDTH (T_WIDTH)
    ) u_tap_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_rd_en     (w_rd_en),
        .i_rd_idx    (r_k),
        .o_tap_valid (tap_valid),
        .o_tap_idx   (tap_idx),
        .o_tap_last  (tap_last)
    );

    // Gate so the MAC sees zero rather than stale RAM data between bursts.
    assign tap_data = tap_valid ? ram_rdata : '0;

endmodule : fir_delay_line_ctrl
`default_nettype wire

// File: doc/fir_delay_line_ctrl.md
Name: fir_delay_line_ctrl

Overview:
- Sequences the single-port sample RAM as a circular FIR delay line.
- Each accepted input sample is written at the write pointer.
- The controller then reads back the newest TAPS samples, newest first, and streams them with tap indices to the FIR MAC stage.
- Sits between the sample source (valid/ready) and the MAC; it is the sole master of the RAM's cs/we/addr/w_data.

Parameters:
- A_WIDTH, 16, RAM address width; delay-line depth is 2**A_WIDTH and the pointer wraps modulo that.
- D_WIDTH, 24, sample width.
- TAPS, 32, number of samples read per output; legal range 2..2**A_WIDTH.
- T_WIDTH, $clog2(TAPS), tap index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  controller can accept a sample
- in_data  in  D_WIDTH  input sample
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_addr  out  A_WIDTH  RAM address
- ram_wdata  out  D_WIDTH  RAM write data
- ram_rdata  in  D_WIDTH  RAM read data, registered, 1-cycle latency
- tap_valid  out  1  tap_data/tap_idx valid
- tap_data  out  D_WIDTH  delayed sample x[n-tap_idx]
- tap_idx  out  T_WIDTH  tap index, 0 = newest
- tap_last  out  1  marks tap_idx == TAPS-1
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, wr_ptr=0, k=0.
  - ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - tap_valid=0, tap_last=0, tap_idx=0, tap_data=0, busy=0, in_ready=1 after the edge.
  - RAM contents are never cleared by the controller.
- States:
  - IDLE:
    - in_ready=1, ram_cs=0, ram_we=0.
    - On in_valid: latch in_data, go to WRITE.
  - WRITE (1 cycle):
    - ram_cs=1, ram_we=1, ram_addr=wr_ptr, ram_wdata=latched sample.
    - Set k=0, go to READ.
  - READ (TAPS cycles):
    - ram_cs=1, ram_we=0, ram_addr=(wr_ptr-k) mod 2**A_WIDTH.
    - k increments each cycle; after k==TAPS-1 go to DRAIN.
  - DRAIN (1 cycle):
    - ram_cs=0; the last tap is presented.
    - wr_ptr <= wr_ptr+1 (wraps at 2**A_WIDTH-1 -> 0); go to IDLE.
- RAM port drive:
  - ram_cs, ram_we, ram_addr and ram_wdata are combinational decodes of registered state only; no input-to-output paths.
  - ram_addr=wr_ptr and ram_wdata=latched sample whenever cs=0.
- Tap output:
  - tap_valid is the READ-state flag delayed one cycle; tap_idx is k delayed one cycle.
  - tap_data = ram_rdata in the same cycle.
  - tap_last = tap_valid && tap_idx==TAPS-1.
- Timing: with accept at cycle 0, the write is at cycle 1 and tap k is valid at cycle k+3.
  - Tap 0 is the sample just written: the write commits at the cycle-1 edge and is read at the cycle-2 edge.
  - IDLE is re-entered at cycle TAPS+3; minimum sample period is TAPS+3 cycles.
- Backpressure:
  - in_ready=0 whenever busy.
  - in_valid held during busy is not consumed and does not alter in_data latching.
  - The sample is accepted on the first IDLE cycle.
- Wrap-around: wr_ptr-k uses modulo-2**A_WIDTH unsigned subtraction. Example: wr_ptr=1, k=3 gives DEPTH-2.
- Reset mid-operation:
  - Any state returns to IDLE next cycle; an in-flight tap_valid is cleared.
  - A write already committed stays in RAM, but wr_ptr returns to 0.
- No tap output ever occurs without a preceding accepted sample.
- Simultaneous rst and in_valid: rst wins; the sample is not accepted.

Decomposition:
- Package fir_pkg:
  - state enum typedef (IDLE, WRITE, READ, DRAIN).
  - default A_WIDTH/D_WIDTH/TAPS constants shared with the MAC and RAM.
- Optional sub-module fir_tap_pipe: the 1-cycle tap_valid/tap_idx/tap_last alignment register stage.
- Everything else lives in the controller; expected 150-250 RTL lines.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with in_valid=1.
  - Required: in_ready=1 after release, ram_cs=0, tap_valid=0, no RAM write, wr_ptr=0.
- Single sample (TAPS=4, RAM preloaded addr i = i+0x100):
  - Stimulus: in_data=0xABCDEF at wr_ptr=0.
  - Required: write at addr 0 on cycle 1; reads at addr 0, FFFF, FFFE, FFFD.
  - Required: taps 0xABCDEF, 0x100FFFF-truncated preload values in order; tap_last only on idx 3, cycle 6.
- Wrap (A_WIDTH=4, TAPS=4):
  - Stimulus: drive 17 samples.
  - Required: 16th write at addr 15, 17th at addr 0; 17th reads addr 0, 15, 14, 13; outputs match a golden circular buffer.
- Backpressure:
  - Stimulus: hold in_valid=1 continuously with incrementing data on each accept.
  - Required: accepts exactly every TAPS+3 cycles; in_ready=0 throughout busy; no sample lost or duplicated.
- Reset mid-READ:
  - Stimulus: rst during k=2.
  - Required: tap_valid=0 next cycle, state IDLE; next sample writes addr 0 with a correct 1-cycle-later tap stream.
- Back-to-back random:
  - Stimulus: 200 random samples with random in_valid gaps.
  - Required: scoreboard confirms tap_data == x[n-tap_idx] for all taps, and exactly one tap_last per accepted sample.
